// File: rtl/lfsr_pkg.sv
// Shared constants, state encoding and LFSR step for the LFSR decryptor.
package lfsr_pkg;

    localparam int NUM_PTRN = 9;
    localparam int MSG_LEN  = 64;
    localparam int MIN_PRE  = 10;
    localparam int MAX_PRE  = 15;

    localparam logic [6:0] LFSR_PTRN [NUM_PTRN] = '{
        7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
    };

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        TRAIN,
        STRIP,
        PASS,
        DONE
    } state_t;

    // Shift left, feedback is the parity of the tapped bits.
    function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] p);
        return {s[5:0], ^(s & p)};
    endfunction

endpackage

// File: rtl/lfsr_decrypt_if.sv
// Handshake, data and status bundle of the LFSR decryptor.
interface lfsr_decrypt_if;
    logic       req;
    logic       ack;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] ptrn_idx;
    logic [6:0] seed;
    logic       no_match;
    logic [6:0] par_err_cnt;

    modport slave (
        input  req, in_data, in_valid, out_ready,
        output ack, in_ready, out_data, out_valid, ptrn_idx, seed, no_match, par_err_cnt
    );

    modport master (
        output req, in_data, in_valid, out_ready,
        input  ack, in_ready, out_data, out_valid, ptrn_idx, seed, no_match, par_err_cnt
    );
endinterface

// File: rtl/lfsr_cand.sv
// One candidate LFSR with a fixed tap pattern and its still-alive flag.
module lfsr_cand
    import lfsr_pkg::*;
#(
    parameter logic [6:0] PTRN = 7'h60
) (
    input  logic       clk,
    input  logic       init_n,
    input  logic       load,
    input  logic       step,
    input  logic       train,
    input  logic [6:0] din,
    output logic [6:0] state_nxt,
    output logic       alive_nxt
);

    logic [6:0] state;
    logic       alive;

    assign state_nxt = lfsr_step(state, PTRN);
    assign alive_nxt = alive & (state_nxt == din);

    // Load the seed on byte 0, then advance once per accepted byte.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state <= 7'd0;
            alive <= 1'b0;
        end else if (load) begin
            state <= din;
            alive <= 1'b1;
        end else if (step) begin
            state <= state_nxt;
            if (train) alive <= alive_nxt;
        end
    end

endmodule

// File: rtl/lfsr_decrypt.sv
// Streaming decryptor: recovers seed and tap pattern from the space
// preamble, strips leading pad spaces and emits the decrypted text.
//
// state | meaning
// IDLE  | waiting for req after reset
// SEED  | byte 0: capture seed, load all candidates
// TRAIN | bytes 1..9: eliminate candidates that disagree
// STRIP | bytes 10..15: drop decoded pad spaces
// PASS  | output every byte through 63 (suppressed if no match)
// DONE  | ack held until the next req
module lfsr_decrypt
    import lfsr_pkg::*;
(
    input  logic          clk,
    input  logic          init_n,
    lfsr_decrypt_if.slave bus
);

    state_t     st;
    logic [5:0] idx;
    logic       fin;

    logic                accept;
    logic [6:0]          cipher;
    logic                par_bad;
    logic [6:0]          cand_nxt [NUM_PTRN];
    logic [NUM_PTRN-1:0] cand_alive_nxt;
    logic [3:0]          first_idx;
    logic [6:0]          sel_state;
    logic [7:0]          plain;

    assign cipher  = bus.in_data[6:0];
    assign par_bad = bus.in_data[7] ^ (^cipher);
    assign accept  = bus.in_valid & bus.in_ready;

    // Once all 64 bytes are in, input is closed while the last output drains.
    assign bus.in_ready = (st == SEED) || (st == TRAIN) ||
                          (((st == STRIP) || (st == PASS)) && !fin &&
                           (!bus.out_valid || bus.out_ready));

    for (genvar g = 0; g < NUM_PTRN; g++) begin : g_cand
        lfsr_cand #(.PTRN(LFSR_PTRN[g])) u_cand (
            .clk       (clk),
            .init_n    (init_n),
            .load      (accept && (st == SEED)),
            .step      (accept && (st != SEED)),
            .train     (st == TRAIN),
            .din       (cipher),
            .state_nxt (cand_nxt[g]),
            .alive_nxt (cand_alive_nxt[g])
        );
    end

    // Lowest-numbered candidate still alive after the current byte.
    always_comb begin
        first_idx = 4'd0;
        for (int k = NUM_PTRN - 1; k >= 0; k--) begin
            if (cand_alive_nxt[k]) first_idx = 4'(k);
        end
    end

    // Decode with the selected candidate's state for this byte.
    always_comb begin
        sel_state = cand_nxt[0];
        for (int k = 0; k < NUM_PTRN; k++) begin
            if (bus.ptrn_idx == 4'(k)) sel_state = cand_nxt[k];
        end
        plain = {1'b0, cipher ^ sel_state} + 8'h20;
    end

    // Control FSM with registered outputs and status.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            st              <= IDLE;
            idx             <= 6'd0;
            fin             <= 1'b0;
            bus.ack         <= 1'b0;
            bus.out_valid   <= 1'b0;
            bus.out_data    <= 8'd0;
            bus.ptrn_idx    <= 4'd0;
            bus.seed        <= 7'd0;
            bus.no_match    <= 1'b0;
            bus.par_err_cnt <= 7'd0;
        end else begin
            if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;
            if (accept) begin
                idx <= idx + 6'd1;
                if (par_bad && (bus.par_err_cnt != 7'h7F))
                    bus.par_err_cnt <= bus.par_err_cnt + 7'd1;
            end
            case (st)
                IDLE, DONE: begin
                    if (bus.req) begin
                        st              <= SEED;
                        idx             <= 6'd0;
                        fin             <= 1'b0;
                        bus.ack         <= 1'b0;
                        bus.ptrn_idx    <= 4'd0;
                        bus.seed        <= 7'd0;
                        bus.no_match    <= 1'b0;
                        bus.par_err_cnt <= 7'd0;
                    end
                end
                SEED: begin
                    if (accept) begin
                        bus.seed <= cipher;
                        st       <= TRAIN;
                    end
                end
                TRAIN: begin
                    if (accept && (idx == 6'(MIN_PRE - 1))) begin
                        bus.ptrn_idx <= first_idx;
                        bus.no_match <= ~|cand_alive_nxt;
                        st           <= (|cand_alive_nxt) ? STRIP : PASS;
                    end
                end
                STRIP: begin
                    if (accept) begin
                        if (plain != 8'h20) begin
                            bus.out_data  <= plain;
                            bus.out_valid <= 1'b1;
                            st            <= PASS;
                        end else if (idx == 6'(MAX_PRE)) begin
                            st <= PASS;
                        end
                    end
                end
                PASS: begin
                    if (accept) begin
                        if (!bus.no_match) begin
                            bus.out_data  <= plain;
                            bus.out_valid <= 1'b1;
                        end
                        if (idx == 6'(MSG_LEN - 1)) fin <= 1'b1;
                    end else if (fin && (!bus.out_valid || bus.out_ready)) begin
                        fin     <= 1'b0;
                        bus.ack <= 1'b1;
                        st      <= DONE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_decrypt.sv
// Scoreboard bench for lfsr_decrypt: messages are encrypted here, the
// expected plaintext is queued at issue time and a monitor pops on output.
module tb_lfsr_decrypt;

    localparam logic [6:0] PTRN_TB [9] = '{
        7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
    };
    localparam string WATSON = "Mr. Watson, come here. I want to see you.";
    localparam string SHORT  = "Hi! LFSR test";

    logic clk = 1'b0;
    logic init_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   rand_rdy = 1'b0;
    bit   gap_on = 1'b0;

    logic [7:0] exp_q [$];
    logic [7:0] cbuf [64];
    logic       hold_pend = 1'b0;
    logic [7:0] hold_data = 8'd0;

    lfsr_decrypt_if bus();

    lfsr_decrypt dut (
        .clk    (clk),
        .init_n (init_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [6:0] step7(input logic [6:0] s, input logic [6:0] p);
        return {s[5:0], ^(s & p)};
    endfunction

    // Encrypt a padded message into cbuf; optionally queue the expected text.
    task automatic build_msg(input int pi, input logic [6:0] sd, input int pre,
                             input string msg, input bit expect_out);
        logic [6:0] s;
        logic [7:0] pl;
        logic [6:0] c;
        s = sd;
        for (int i = 0; i < 64; i++) begin
            if (i < pre || (i - pre) >= msg.len()) pl = 8'h20;
            else pl = msg[i - pre];
            c = 7'(pl - 8'h20) ^ s;
            cbuf[i] = {^c, c};
            if (expect_out && i >= pre) exp_q.push_back(pl);
            s = step7(s, PTRN_TB[pi]);
        end
    endtask

    // Downstream ready: always on, or random when stalling is exercised.
    always @(posedge clk) begin
        #1;
        bus.out_ready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    // Output monitor: pops the scoreboard on each handshake, checks holds.
    always @(negedge clk) begin
        if (!init_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_data", bus.out_data, hold_data);
                hold_pend = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL extra_output: got 0x%0h, expected no output", bus.out_data);
                end else begin
                    check("out_data", bus.out_data, exp_q.pop_front());
                end
            end else if (bus.out_valid) begin
                hold_pend = 1'b1;
                hold_data = bus.out_data;
            end
        end
    end

    task automatic start_msg();
        @(posedge clk); #1;
        bus.req = 1'b1;
        @(posedge clk); #1;
        bus.req = 1'b0;
        check("in_ready_seed", bus.in_ready, 1);
        check("ack_cleared", bus.ack, 0);
        check("par_cleared", bus.par_err_cnt, 0);
        check("no_match_cleared", bus.no_match, 0);
    endtask

    task automatic push_byte(input logic [7:0] b);
        int t;
        int n;
        n = gap_on ? $urandom_range(0, 2) : 0;
        bus.in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (!bus.in_ready) check("accept_timeout", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) push_byte(cbuf[i]);
    endtask

    task automatic finish_msg(input string name, input logic [6:0] e_seed, input logic [3:0] e_pi,
                              input logic e_nm, input logic [6:0] e_par);
        int t;
        t = 0;
        while (!bus.ack && t < 300) begin
            t++;
            @(negedge clk);
        end
        check({name, "_ack"}, bus.ack, 1);
        check({name, "_in_ready_done"}, bus.in_ready, 0);
        check({name, "_seed"}, bus.seed, e_seed);
        check({name, "_ptrn_idx"}, bus.ptrn_idx, e_pi);
        check({name, "_no_match"}, bus.no_match, e_nm);
        check({name, "_par_err_cnt"}, bus.par_err_cnt, e_par);
        check({name, "_missing_outputs"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_ack"}, bus.ack, 0);
        check({name, "_in_ready"}, bus.in_ready, 0);
        check({name, "_out_valid"}, bus.out_valid, 0);
        check({name, "_out_data"}, bus.out_data, 0);
        check({name, "_ptrn_idx"}, bus.ptrn_idx, 0);
        check({name, "_seed"}, bus.seed, 0);
        check({name, "_no_match"}, bus.no_match, 0);
        check({name, "_par_err_cnt"}, bus.par_err_cnt, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] sd;
        logic [6:0] c;
        string      nm;

        bus.req      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        init_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        init_n = 1'b1;
        @(posedge clk); #1;
        check("idle_in_ready", bus.in_ready, 0);

        // Reference message, preamble 10.
        build_msg(0, 7'h01, 10, WATSON, 1'b1);
        start_msg();
        feed(64);
        finish_msg("watson", 7'h01, 4'd0, 1'b0, 7'd0);

        // Every pattern with seeds 0x01, 0x7F and a random one, preamble 15.
        for (int p = 0; p < 9; p++) begin
            for (int k = 0; k < 3; k++) begin
                sd = (k == 0) ? 7'h01 : (k == 1) ? 7'h7F : 7'($urandom_range(1, 127));
                nm = $sformatf("sweep_p%0d_s%02h", p, sd);
                build_msg(p, sd, 15, SHORT, 1'b1);
                start_msg();
                feed(64);
                finish_msg(nm, sd, 4'(p), 1'b0, 7'd0);
            end
        end

        // Parity bit of byte 3 flipped: counted, text unaffected.
        build_msg(0, 7'h01, 10, WATSON, 1'b1);
        cbuf[3] = cbuf[3] ^ 8'h80;
        start_msg();
        feed(64);
        finish_msg("parity", 7'h01, 4'd0, 1'b0, 7'd1);

        // Byte 5 cipher corrupted (parity kept consistent): no candidate survives.
        build_msg(2, 7'h35, 12, WATSON, 1'b0);
        c = cbuf[5][6:0] ^ 7'h01;
        cbuf[5] = {^c, c};
        start_msg();
        feed(64);
        finish_msg("no_match", 7'h35, 4'd0, 1'b1, 7'd0);

        // Random downstream stalls and gapped input.
        rand_rdy = 1'b1;
        gap_on   = 1'b1;
        build_msg(4, 7'h5A, 13, WATSON, 1'b1);
        start_msg();
        feed(64);
        finish_msg("stall", 7'h5A, 4'd4, 1'b0, 7'd0);

        // Reset at byte 30 aborts the message; a clean one follows.
        build_msg(6, 7'h22, 11, WATSON, 1'b1);
        start_msg();
        feed(30);
        init_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset_vals("mid_reset");
        @(posedge clk); #1;
        init_n   = 1'b1;
        rand_rdy = 1'b0;
        gap_on   = 1'b0;
        @(posedge clk); #1;
        check("post_reset_in_ready", bus.in_ready, 0);
        build_msg(7, 7'h4C, 10, WATSON, 1'b1);
        start_msg();
        feed(64);
        finish_msg("after_reset", 7'h4C, 4'd7, 1'b0, 7'd0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
